// File: rtl/pwconv_ctrl_pkg.sv
// rtl/pwconv_ctrl_pkg.sv - shared types and defaults for the pointwise-conv controller
package pwconv_ctrl_pkg;

  localparam int N_CH_DEF  = 32;
  localparam int N_POS_DEF = 16;
  localparam int LAT_DEF   = 3;
  localparam int CNT_W     = 5;
  localparam int POS_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pwconv_ctrl_if.sv
// rtl/pwconv_ctrl_if.sv - control, SRAM-issue and result handshake bundle
interface pwconv_ctrl_if;
  import pwconv_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [CNT_W-1:0] weight_addr;
  logic [POS_W-1:0] data_addr;
  logic             conv_en;
  logic [CNT_W-1:0] cnt_issue;
  logic [POS_W-1:0] pos_issue;
  logic             res_valid;
  logic             res_last;

  // host side: requests layers and consumes results
  modport master (
    output start, abort, out_ready,
    input  busy, done, rd_en, weight_addr, data_addr, conv_en,
           cnt_issue, pos_issue, res_valid, res_last
  );

  // controller side
  modport slave (
    input  start, abort, out_ready,
    output busy, done, rd_en, weight_addr, data_addr, conv_en,
           cnt_issue, pos_issue, res_valid, res_last
  );

endinterface

// File: rtl/pwconv_ctrl_vpipe.sv
// rtl/pwconv_ctrl_vpipe.sv - enable-gated valid/last delay line matching the read+conv latency
module pwconv_ctrl_vpipe
  import pwconv_ctrl_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  logic clr,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [LAT-1:0] v_q;
  logic [LAT-1:0] l_q;

  // shift only when the datapath advances; clr flushes everything in flight
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      v_q <= '0;
      l_q <= '0;
    end else if (clr) begin
      v_q <= '0;
      l_q <= '0;
    end else if (en) begin
      v_q[0] <= in_valid;
      l_q[0] <= in_last;
      for (int i = 1; i < LAT; i++) begin
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign out_last  = l_q[LAT-1];

endmodule

// File: rtl/pwconv_ctrl.sv
// rtl/pwconv_ctrl.sv - layer sequencer: issues (pos,cnt) reads and tracks results to completion
module pwconv_ctrl
  import pwconv_ctrl_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int N_POS = N_POS_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_b,
  pwconv_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CH - 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] cnt_issue_q;
  logic [POS_W-1:0] pos_issue_q;
  logic             busy_q;
  logic             done_q;

  logic adv;
  logic issue;
  logic issue_last;
  logic pipe_valid;
  logic pipe_last;
  logic last_hs;

  // the pipe may move when the current result is taken or there is none
  assign adv        = bus.out_ready | ~pipe_valid;
  assign issue      = (state == RUN) & adv;
  assign issue_last = issue & (cnt == CNT_MAX) & (pos == POS_MAX);
  assign last_hs    = pipe_valid & pipe_last & bus.out_ready;

  pwconv_ctrl_vpipe #(.LAT(LAT)) u_vpipe (
    .clk       (clk),
    .rst_b     (rst_b),
    .en        (adv),
    .clr       (bus.abort),
    .in_valid  (issue),
    .in_last   (issue_last),
    .out_valid (pipe_valid),
    .out_last  (pipe_last)
  );

  // sequencer FSM with position/channel counters and issue tags
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      cnt         <= '0;
      pos         <= '0;
      cnt_issue_q <= '0;
      pos_issue_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.abort) begin
      state       <= IDLE;
      cnt         <= '0;
      pos         <= '0;
      cnt_issue_q <= '0;
      pos_issue_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (issue) begin
        cnt_issue_q <= cnt;
        pos_issue_q <= pos;
        if (cnt == CNT_MAX) begin
          cnt <= '0;
          pos <= (pos == POS_MAX) ? '0 : pos + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (issue_last) state <= DRAIN;
        end
        DRAIN: begin
          // the last result leaving is the moment the pipe goes empty
          if (last_hs) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = issue;
  assign bus.weight_addr = cnt;
  assign bus.data_addr   = pos;
  // adv is idle-high; hold it low while reset is applied so every output reads 0
  assign bus.conv_en     = adv & rst_b;
  assign bus.cnt_issue   = cnt_issue_q;
  assign bus.pos_issue   = pos_issue_q;
  assign bus.res_valid   = pipe_valid;
  assign bus.res_last    = pipe_last & pipe_valid;

endmodule

// File: tb/tb_pwconv_ctrl.sv
// tb/tb_pwconv_ctrl.sv - scoreboard bench for pwconv_ctrl
module tb_pwconv_ctrl;
  import pwconv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  pwconv_ctrl_if bus();

  pwconv_ctrl #(.N_CH(32), .N_POS(16), .LAT(3)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base = 0;
  int rel;

  logic [8:0] addr_q[$];
  bit         last_q[$];

  int first_rd, last_rd, n_rd, first_val, last_at, n_last;
  int done_at, n_done, n_busy, n_hs, stall_cnt;
  bit prev_stall, prev_issue;
  logic [8:0] stall_addr, prev_iaddr;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops expected issues and results as the DUT presents them
  always @(negedge clk) begin
    if (rst_b) begin
      rel = cyc - base;
      if (bus.rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = rel;
        last_rd = rel;
        if (addr_q.size() == 0) chk("issue_unexpected", 1, 0);
        else chk("issue_addr", {bus.data_addr, bus.weight_addr}, addr_q.pop_front());
      end
      if (prev_issue) chk("issue_tag", {bus.pos_issue, bus.cnt_issue}, prev_iaddr);
      prev_issue = bus.rd_en;
      prev_iaddr = {bus.data_addr, bus.weight_addr};
      if (bus.res_valid && first_val < 0) first_val = rel;
      if (bus.res_last) n_last++;
      if (bus.res_valid && bus.out_ready) begin
        n_hs++;
        if (last_q.size() == 0) chk("result_unexpected", 1, 0);
        else chk("res_last", bus.res_last, last_q.pop_front());
        if (bus.res_last) last_at = rel;
      end
      if (bus.done) begin
        n_done++;
        done_at = rel;
      end
      if (bus.busy) n_busy++;
      if (bus.res_valid && !bus.out_ready) begin
        stall_cnt++;
        chk("stall_conv_en", bus.conv_en, 0);
        chk("stall_rd_en", bus.rd_en, 0);
        if (prev_stall) chk("stall_hold", {bus.data_addr, bus.weight_addr}, stall_addr);
        prev_stall = 1'b1;
        stall_addr = {bus.data_addr, bus.weight_addr};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic reset_stats();
    first_rd = -1; last_rd = -1; n_rd = 0; first_val = -1; last_at = -1;
    n_last = 0; done_at = -1; n_done = 0; n_busy = 0; n_hs = 0;
    stall_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic flush_model();
    addr_q.delete();
    last_q.delete();
    prev_issue = 1'b0;
  endtask

  // start in relative cycle 0 and load the full expected issue/result order
  task automatic start_run();
    @(posedge clk); #1;
    base = cyc;
    reset_stats();
    for (int p = 0; p < 16; p++) begin
      for (int c = 0; c < 32; c++) begin
        addr_q.push_back({p[3:0], c[4:0]});
        last_q.push_back(p == 15 && c == 31);
      end
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - base < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_timeout", int'(n_done > 0), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_conv_en"}, bus.conv_en, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_last"}, bus.res_last, 0);
    chk({tag, "_addr"}, {bus.data_addr, bus.weight_addr}, 0);
    chk({tag, "_tags"}, {bus.pos_issue, bus.cnt_issue}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    reset_stats();
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_b = 1'b1;
    repeat (2) @(posedge clk);

    // full run, no stalls
    start_run();
    wait_done(700);
    chk("t1_first_rd", first_rd, 1);
    chk("t1_last_rd", last_rd, 512);
    chk("t1_n_rd", n_rd, 512);
    chk("t1_first_valid", first_val, 4);
    chk("t1_last_at", last_at, 515);
    chk("t1_n_last", n_last, 1);
    chk("t1_done_at", done_at, 516);
    chk("t1_n_done", n_done, 1);
    chk("t1_n_busy", n_busy, 516);
    chk("t1_n_hs", n_hs, 512);
    chk("t1_addr_q", addr_q.size(), 0);
    chk("t1_last_q", last_q.size(), 0);

    // backpressure for 5 cycles while results are valid
    start_run();
    wait_rel(20);
    bus.out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_done(700);
    chk("t2_stall_cnt", stall_cnt, 5);
    chk("t2_n_rd", n_rd, 512);
    chk("t2_n_hs", n_hs, 512);
    chk("t2_n_done", n_done, 1);
    chk("t2_done_at", done_at, 521);
    chk("t2_addr_q", addr_q.size(), 0);
    chk("t2_last_q", last_q.size(), 0);

    // start while busy is ignored
    start_run();
    wait_rel(50);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(700);
    chk("t3_done_at", done_at, 516);
    chk("t3_n_done", n_done, 1);
    chk("t3_n_hs", n_hs, 512);
    chk("t3_n_rd", n_rd, 512);

    // abort at cycle 100, together with a start that must lose
    start_run();
    wait_rel(100);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    flush_model();
    chk("t4_busy", bus.busy, 0);
    chk("t4_res_valid", bus.res_valid, 0);
    chk("t4_rd_en", bus.rd_en, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_done", n_done, 0);
    chk("t4_idle_rd", n_rd, 100);
    start_run();
    wait_done(700);
    chk("t4_restart_first_rd", first_rd, 1);
    chk("t4_restart_done_at", done_at, 516);
    chk("t4_restart_n_hs", n_hs, 512);

    // reset asserted in DRAIN
    start_run();
    wait_rel(514);
    rst_b = 1'b0;
    #1;
    chk_outputs_zero("t5");
    flush_model();
    chk("t5_no_done", n_done, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    start_run();
    wait_done(700);
    chk("t5_first_rd", first_rd, 1);
    chk("t5_done_at", done_at, 516);
    chk("t5_n_hs", n_hs, 512);
    chk("t5_addr_q", addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
